// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - sweeps a 4-input function through codes 0..15 and checks its truth table (optional: SWEEP_STOP_ON_FAIL_EN)
module truth_table_sweeper #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic        f_in,
    output logic [3:0]  vec_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth_table,
    output logic [4:0]  mismatch_count,
    output logic [3:0]  first_fail_idx,
    output logic        pass
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t             state;
    state_t             state_next;
    logic [3:0]         code;
    logic [CNT_W-1:0]   hold_cnt;
    logic [15:0]        exp_q;
    logic               accept;
    logic               sample;
    logic               miss;
    logic               sweep_end;
    logic [4:0]         mismatch_next;

    // A new sweep is only taken from IDLE; requests in DRIVE/DONE are dropped.
    assign accept = (state == IDLE) && start;

    // The function output is looked at only on the last edge of each hold.
    assign sample = (state == DRIVE) && (hold_cnt == HOLD_LAST);

    // Compare against the copy of expected captured at acceptance.
    assign miss = sample && (f_in != exp_q[code]);

    // Count including the sample being taken this edge; cannot exceed 16.
    assign mismatch_next = mismatch_count + {4'd0, miss};

`ifdef SWEEP_STOP_ON_FAIL_EN
    // Abort the sweep right after the first failing sample.
    assign sweep_end = sample && ((code == 4'd15) || miss);
`else
    // Every code is always visited.
    assign sweep_end = sample && (code == 4'd15);
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)     state_next = DRIVE;
            DRIVE:   if (sweep_end) state_next = DONE;
            DONE:                   state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Status outputs decoded straight from the state register.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            DRIVE:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Code and hold counter; vec_out is the code register itself so it never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code     <= 4'd0;
            hold_cnt <= '0;
        end else if (accept) begin
            code     <= 4'd0;
            hold_cnt <= '0;
        end else if (state == DRIVE) begin
            if (sample) begin
                hold_cnt <= '0;
                if (!sweep_end) begin
                    code <= code + 4'd1;
                end
            end else begin
                hold_cnt <= hold_cnt + CNT_W'(1);
            end
        end else if (state == DONE) begin
            code     <= 4'd0;
            hold_cnt <= '0;
        end
    end

    assign vec_out = code;

    // Expected latch and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q          <= 16'h0000;
            truth_table    <= 16'h0000;
            mismatch_count <= 5'd0;
            first_fail_idx <= 4'd0;
        end else if (accept) begin
            exp_q          <= expected;
            truth_table    <= 16'h0000;
            mismatch_count <= 5'd0;
            first_fail_idx <= 4'd0;
        end else if (sample) begin
            truth_table[code] <= f_in;
            mismatch_count    <= mismatch_next;
            if (miss && (mismatch_count == 5'd0)) begin
                first_fail_idx <= code;
            end
        end
    end

    // Verdict is settled on the edge entering DONE so it is valid alongside done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass <= 1'b0;
        end else if (accept) begin
            pass <= 1'b0;
        end else if (sweep_end) begin
            pass <= (mismatch_next == 5'd0);
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - scoreboard bench for truth_table_sweeper
module tb_truth_table_sweeper;

    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] expected = 16'h0000;
    logic        f_in;
    logic [3:0]  vec_out;
    logic        busy;
    logic        done;
    logic [15:0] truth_table;
    logic [4:0]  mismatch_count;
    logic [3:0]  first_fail_idx;
    logic        pass;
    logic        f_zero = 1'b0;

    int cyc = 0;
    int n_total = 0;
    int n_pass = 0;

    typedef struct {
        int          k;
        int          done_edge;
        logic [15:0] tt;
        logic [4:0]  mm;
        logic [3:0]  ffi;
        logic        ps;
    } exp_t;

    exp_t sb[$];

    truth_table_sweeper #(.HOLD_CYCLES(H), .CNT_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .expected       (expected),
        .f_in           (f_in),
        .vec_out        (vec_out),
        .busy           (busy),
        .done           (done),
        .truth_table    (truth_table),
        .mismatch_count (mismatch_count),
        .first_fail_idx (first_fail_idx),
        .pass           (pass)
    );

    // Function block under sweep: odd parity of {A,B,C,D}.
    assign f_in = f_zero ? 1'b0 : ^vec_out;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: tracks vec_out while busy and scores each done pulse against the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (busy && sb.size() > 0)
                chk("vec_out_step", int'(vec_out), (cyc - sb[0].k) / H);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_edge", cyc, e.done_edge);
                    chk("truth_table", int'(truth_table), int'(e.tt));
                    chk("mismatch_count", int'(mismatch_count), int'(e.mm));
                    chk("first_fail_idx", int'(first_fail_idx), int'(e.ffi));
                    chk("pass", int'(pass), int'(e.ps));
                end
            end
        end
    end

    task automatic sweep(input logic [15:0] e, input logic [15:0] tt, input logic [4:0] mm,
                         input logic [3:0] ffi, input logic ps, input int n_codes);
        exp_t x;
        @(negedge clk);
        start    = 1'b1;
        expected = e;
        @(posedge clk);
        #1;
        x.k = cyc; x.done_edge = cyc + n_codes * H;
        x.tt = tt; x.mm = mm; x.ffi = ffi; x.ps = ps;
        sb.push_back(x);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_empty();
        int i;
        for (i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        if (i == 300) begin
            chk("done_timeout", 1, 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_vec(input logic [3:0] v);
        int i;
        for (i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy && vec_out == v) break;
        end
        if (i == 300) chk("vec_timeout", 1, 0);
    endtask

    initial begin
        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_vec_out", int'(vec_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_truth_table", int'(truth_table), 0);
        chk("rst_mismatch", int'(mismatch_count), 0);
        chk("rst_pass", int'(pass), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Matching sweep.
        sweep(16'h6996, 16'h6996, 5'd0, 4'd0, 1'b1, 16);
        wait_empty();

        // One wrong expected bit at code 0.
`ifdef SWEEP_STOP_ON_FAIL_EN
        sweep(16'h6997, 16'h0000, 5'd1, 4'd0, 1'b0, 1);
`else
        sweep(16'h6997, 16'h6996, 5'd1, 4'd0, 1'b0, 16);
`endif
        wait_empty();

        // Restart attempt and expected change mid-sweep are ignored.
        sweep(16'h6996, 16'h6996, 5'd0, 4'd0, 1'b1, 16);
        wait_vec(4'd5);
        start    = 1'b1;
        expected = 16'h0000;
        @(negedge clk);
        start = 1'b0;
        wait_empty();

        // Results clear on acceptance, second sweep passes.
        sweep(16'h6996, 16'h6996, 5'd0, 4'd0, 1'b1, 16);
        chk("clr_truth_table", int'(truth_table), 0);
        chk("clr_pass", int'(pass), 0);
        chk("clr_busy", int'(busy), 1);
        wait_empty();

        // Asynchronous reset mid-sweep.
        sweep(16'h6996, 16'h6996, 5'd0, 4'd0, 1'b1, 16);
        wait_vec(4'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vec_out", int'(vec_out), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_truth_table", int'(truth_table), 0);
        chk("arst_mismatch", int'(mismatch_count), 0);
        chk("arst_pass", int'(pass), 0);
        void'(sb.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        sweep(16'h6996, 16'h6996, 5'd0, 4'd0, 1'b1, 16);
        wait_empty();

`ifdef SWEEP_STOP_ON_FAIL_EN
        // Early abort at code 1 with F stuck low.
        f_zero = 1'b1;
        sweep(16'h6996, 16'h0000, 5'd1, 4'd1, 1'b0, 2);
        wait_empty();
        f_zero = 1'b0;
`endif

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Self-timed stimulus and capture stage wrapped around a 4-input combinational function block with inputs A, B, C, D and output F.
- Upstream role: drives {A,B,C,D} through codes 0..15, holding each code for a programmable number of cycles.
- Downstream role: samples F at the end of each hold, builds the 16-entry truth table and compares it against an expected minterm mask.
- Replaces hand-written 16-step stimulus sequences with a synthesizable, start/done-handshaked sweep usable on silicon and in simulation.

Parameters:
- HOLD_CYCLES, 4, cycles each code is held before F is sampled; legal range 1..255.
- CNT_W, 8, width of the internal hold counter; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  sweep request; sampled only in IDLE.
- expected  in  16  expected truth table; bit i = F for code i; latched on start acceptance.
- f_in  in  1  F output of the function block under sweep.
- vec_out  out  4  stimulus {A,B,C,D}; bit3 = A, bit0 = D.
- busy  out  1  high from start acceptance until the done cycle (inclusive of DRIVE, exclusive of DONE).
- done  out  1  one-cycle pulse at sweep end.
- truth_table  out  16  captured F values; bit i = F for code i.
- mismatch_count  out  5  number of codes where captured != expected (0..16).
- first_fail_idx  out  4  lowest code that mismatched; valid only when mismatch_count != 0.
- pass  out  1  high when the last completed sweep had mismatch_count == 0; held until next start.

Behaviour:
Reset (asynchronous, rst_n low):
- vec_out=0, busy=0, done=0, truth_table=0, mismatch_count=0, first_fail_idx=0, pass=0; FSM enters IDLE.
- Reset mid-sweep discards all partial results.

FSM states: IDLE, DRIVE, DONE.
- IDLE: vec_out=0; results hold their last values. On start=1 at edge k:
  - latch expected; clear truth_table, mismatch_count, first_fail_idx and pass; set hold_cnt=0 and code=0; busy=1; go to DRIVE.
- DRIVE: vec_out=code, registered and glitch-free. hold_cnt increments each edge.
  - At the edge where hold_cnt==HOLD_CYCLES-1, sample f_in: truth_table[code] <= f_in.
  - If f_in != latched expected[code]: increment mismatch_count; if this is the first mismatch, first_fail_idx <= code.
  - Then, if code==15, go to DONE; otherwise code <= code+1 and hold_cnt <= 0.
- DONE: one cycle only. done=1, busy=0, pass <= (final mismatch_count==0). vec_out returns to 0 on the edge leaving DONE. Next state is IDLE.

Timing (start accepted at edge k):
- Code n is driven from edge k+n*HOLD_CYCLES and sampled at edge k+(n+1)*HOLD_CYCLES.
- done is high in the cycle following edge k+16*HOLD_CYCLES.
- HOLD_CYCLES=1: each code is driven for one cycle and sampled on the next edge.
- f_in is sampled only at the end of a hold; glitches earlier in the hold are ignored.

Boundary conditions:
- start is ignored in DRIVE and DONE; no queuing.
- start held high continuously re-triggers a new sweep on the first IDLE cycle after DONE.
- Changes to expected after acceptance have no effect on the current sweep.
- mismatch_count saturates naturally at 16; no wrap is possible.

Optional Feature:
SWEEP_STOP_ON_FAIL_EN
- Defined: on the first mismatch, the sweep aborts after that sample and goes straight to DONE. Bits of truth_table for codes not yet reached stay 0. mismatch_count=1, pass=0, done pulses early.
- Undefined: all 16 codes are always swept; no early exit logic is present.

Test Plan:
Bench models the function block as f_in = A^B^C^D, driven combinationally from vec_out.
1. rst_n low for 3 cycles, then high -> vec_out=0, busy=0, done=0, truth_table=16'h0000, mismatch_count=0, pass=0.
2. HOLD_CYCLES=4, expected=16'h6996, start pulsed at edge k -> busy for 64 cycles; vec_out steps 0..15 every 4 cycles; done high in the cycle after edge k+64; truth_table=16'h6996; mismatch_count=0; pass=1.
3. expected=16'h6997 -> truth_table=16'h6996, mismatch_count=1, first_fail_idx=0, pass=0.
4. start re-pulsed at code 5 and expected changed to 16'h0000 mid-sweep -> no restart, result identical to scenario 2. start pulsed after done -> results cleared at acceptance, second sweep passes.
5. rst_n low while vec_out=7 -> all outputs go to reset values immediately, without waiting for a clock edge. A subsequent start performs a full 16-code sweep with pass=1.
6. With SWEEP_STOP_ON_FAIL_EN defined, f_in tied to 0, expected=16'h6996 -> abort at code 1; done high in the cycle after edge k+8; first_fail_idx=1, mismatch_count=1, truth_table=16'h0000, pass=0.
